// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory-port arbiter:
//   state_t      - sequencer state encoding (IDLE/ISSUE/WAIT/RESP)
//   OWN_IF/OWN_D - owner encoding (fetch / data requester)
//   MAX_WAIT_DEF - default miss-service bound in WAIT cycles
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int MAX_WAIT_DEF = 64;

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the fetch and data requesters.
// Build option: MEM_ARB_RR_EN selects round-robin on simultaneous requests
// (the requester not served last wins); otherwise data has fixed priority.
// Ports:
//   if_req_i  - fetch request
//   d_req_i   - data request
//   last_i    - last-served owner (only present with MEM_ARB_RR_EN)
//   grant_o   - some requester wins this cycle
//   owner_o   - winning requester (OWN_IF / OWN_D)
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req_i,
    input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_i,
`endif
    output logic grant_o,
    output logic owner_o
);

    always_comb begin
        grant_o = if_req_i | d_req_i;
        owner_o = OWN_IF;
`ifdef MEM_ARB_RR_EN
        if (if_req_i && d_req_i) begin
            owner_o = ~last_i;
        end else if (d_req_i) begin
            owner_o = OWN_D;
        end
`else
        if (d_req_i) begin
            owner_o = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one cache port between instruction fetch and data access. The
// winning request is registered onto the port and held until the cache hits
// (or the WAIT bound expires), then a one-cycle ack returns the read data.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration with a
// last-served pointer; default is fixed data-over-fetch priority.
// Ports:
//   clock, rst_n                 - clock, synchronous active-low reset
//   if_req/if_addr               - fetch request and address
//   if_ack/if_rdata              - fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata    - data request, store flag, address, data
//   d_ack/d_rdata                - data completion pulse and load data
//   err                          - accompanies ack on a timed-out request
//   mem_isWrite/mem_addr/mem_Wdata - registered cache port outputs
//   mem_Rdata/mem_hit            - cache read data and hit
//   busy                         - sequencer not in IDLE
//   owner                        - last granted requester (0=fetch, 1=data)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_SZ  = 10,
    parameter int DATA_SZ  = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [ADDR_SZ-1:0] if_addr,
    output logic               if_ack,
    output logic [DATA_SZ-1:0] if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_SZ-1:0] d_addr,
    input  logic [DATA_SZ-1:0] d_wdata,
    output logic               d_ack,
    output logic [DATA_SZ-1:0] d_rdata,
    output logic               err,
    output logic               mem_isWrite,
    output logic [ADDR_SZ-1:0] mem_addr,
    output logic [DATA_SZ-1:0] mem_Wdata,
    input  logic [DATA_SZ-1:0] mem_Rdata,
    input  logic               mem_hit,
    output logic               busy,
    output logic               owner
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_WAIT);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               owner_q;
    logic               if_ack_q, d_ack_q, err_q;
    logic               mem_isWrite_q;
    logic [ADDR_SZ-1:0] mem_addr_q;
    logic [DATA_SZ-1:0] mem_Wdata_q;
    logic [DATA_SZ-1:0] if_rdata_q, d_rdata_q;
    logic               grant_d, owner_d;
    logic               hit_d, timeout_d;

`ifdef MEM_ARB_RR_EN
    logic last_q;
`endif

    mem_arb_pick u_pick (
        .if_req_i (if_req),
        .d_req_i  (d_req),
`ifdef MEM_ARB_RR_EN
        .last_i   (last_q),
`endif
        .grant_o  (grant_d),
        .owner_o  (owner_d)
    );

    // A hit ends the transaction from either ISSUE or WAIT; the timeout
    // only fires in WAIT and loses to a hit arriving on the same edge.
    assign hit_d     = ((state_q == ISSUE) || (state_q == WAIT)) && mem_hit;
    assign timeout_d = (state_q == WAIT) && !mem_hit && (cnt_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            owner_q       <= OWN_IF;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            err_q         <= 1'b0;
            mem_isWrite_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_Wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_q        <= OWN_IF;
`endif
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q <= owner_d;
                        state_q <= ISSUE;
                        if (owner_d == OWN_D) begin
                            mem_isWrite_q <= d_we;
                            mem_addr_q    <= d_addr;
                            mem_Wdata_q   <= d_wdata;
                        end else begin
                            mem_isWrite_q <= 1'b0;
                            mem_addr_q    <= if_addr;
                            mem_Wdata_q   <= '0;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (hit_d || timeout_d) begin
                        state_q <= RESP;
                        // Drop the write strobe so a store is not repeated.
                        mem_isWrite_q <= 1'b0;
                        err_q         <= timeout_d;
                        if (owner_q == OWN_D) begin
                            d_ack_q <= 1'b1;
                            if (hit_d) d_rdata_q <= mem_Rdata;
                        end else begin
                            if_ack_q <= 1'b1;
                            if (hit_d) if_rdata_q <= mem_Rdata;
                        end
                    end else if (state_q == ISSUE) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
`ifdef MEM_ARB_RR_EN
                    last_q  <= owner_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign err         = err_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_isWrite = mem_isWrite_q;
    assign mem_addr    = mem_addr_q;
    assign mem_Wdata   = mem_Wdata_q;
    assign owner       = owner_q;
    assign busy        = (state_q != IDLE);

endmodule
